// File: rtl/pulse_sched.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sched
// Purpose  : Round-robin scheduler sharing one stretched pulse output among
//            NREQ single-cycle event sources. Events are latched as pending,
//            one source is granted at a time, and a pulse of programmable
//            length is driven, tagged with the winning source ID. A minimum
//            low gap of GAP cycles separates consecutive pulses.
// Ports    : clk     - clock
//            reset   - synchronous active-high reset
//            req     - per-source event strobes
//            len     - pulse length in cycles, sampled at grant (0 acts as 1)
//            o       - stretched pulse
//            o_id    - source of the current/last pulse
//            busy    - scheduler not idle
//            pend    - registered pending flags
//            merged  - event absorbed into an already-pending flag (1 cycle)
// Revision : 1.0 - initial release
// ============================================================================
module pulse_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LW   = 4,
    parameter int GAP  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   len,
    output logic            o,
    output logic [IDW-1:0]  o_id,
    output logic            busy,
    output logic [NREQ-1:0] pend,
    output logic [NREQ-1:0] merged
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [3:0]     GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [IDW-1:0] RR_RST   = IDW'(NREQ - 1);
    localparam logic [LW-1:0]  CNT_ONE  = LW'(1);

    state_t          state_q, state_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [3:0]      gcnt_q, gcnt_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [NREQ-1:0] pend_q, pend_d;
    logic [NREQ-1:0] merged_q, merged_d;
    logic            o_q, o_d;
    logic            busy_q, busy_d;

    logic [IDW-1:0]  win_hi, win_lo, win;
    logic            found_hi;
    logic            grant;
    logic [NREQ-1:0] gnt_vec;

    // Round-robin winner: the lowest pending index above rr wins; if none
    // exists, wrap around to the lowest pending index overall. Scanning
    // downward leaves the lowest matching index as the final assignment.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (pend_q[j]) begin
                win_lo = IDW'(j);
            end
            if (pend_q[j] && (j > int'(rr_q))) begin
                win_hi   = IDW'(j);
                found_hi = 1'b1;
            end
        end
        win = found_hi ? win_hi : win_lo;
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        rr_d    = rr_q;
        id_d    = id_q;
        grant   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    grant   = 1'b1;
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (GAP > 0) begin
                    state_d = S_GAP;
                    gcnt_d  = GAP_LOAD;
                end else if (|pend_q) begin
                    // Back-to-back: re-arbitrate on the last high cycle.
                    grant = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gcnt_q != 4'd0) begin
                    gcnt_d = gcnt_q - 4'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (grant) begin
            id_d  = win;
            rr_d  = win;
            cnt_d = (len == '0) ? '0 : len - CNT_ONE;
        end

        gnt_vec = grant ? (NREQ'(1) << win) : '0;

        // A new event on the granted source re-arms its flag; an event on a
        // source that is already pending and not granted is merged.
        pend_d   = (pend_q & ~gnt_vec) | req;
        merged_d = req & pend_q & ~gnt_vec;

        o_d    = (state_d == S_PULSE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            gcnt_q   <= 4'd0;
            rr_q     <= RR_RST;
            id_q     <= '0;
            pend_q   <= '0;
            merged_q <= '0;
            o_q      <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gcnt_q   <= gcnt_d;
            rr_q     <= rr_d;
            id_q     <= id_d;
            pend_q   <= pend_d;
            merged_q <= merged_d;
            o_q      <= o_d;
            busy_q   <= busy_d;
        end
    end

    assign o      = o_q;
    assign o_id   = id_q;
    assign busy   = busy_q;
    assign pend   = pend_q;
    assign merged = merged_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_sched
// Purpose  : Self-checking bench for pulse_sched. Two instances share the
//            stimulus: inst A with GAP=1 and inst B with GAP=0. A behavioural
//            model tracks remaining high/low cycles per instance and is
//            compared on every falling edge; directed scenarios add literal
//            expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LW   = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [LW-1:0]   len = '0;

    logic            oa, ob;
    logic [IDW-1:0]  ida, idb;
    logic            busya, busyb;
    logic [NREQ-1:0] penda, pendb, mrga, mrgb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pulse_sched #(.NREQ(NREQ), .IDW(IDW), .LW(LW), .GAP(1)) u_a (
        .clk(clk), .reset(reset), .req(req), .len(len),
        .o(oa), .o_id(ida), .busy(busya), .pend(penda), .merged(mrga)
    );

    pulse_sched #(.NREQ(NREQ), .IDW(IDW), .LW(LW), .GAP(0)) u_b (
        .clk(clk), .reset(reset), .req(req), .len(len),
        .o(ob), .o_id(idb), .busy(busyb), .pend(pendb), .merged(mrgb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hi = high cycles still to show (incl. current), lo = forced low cycles
    // still to show; both zero means idle and ready to arbitrate.
    int              m_hi  [2];
    int              m_lo  [2];
    int              m_id  [2];
    int              m_rr  [2];
    logic [NREQ-1:0] m_pend[2];
    logic [NREQ-1:0] m_mrg [2];
    int              gapv  [2] = '{1, 0};
    bit              m_valid = 1'b0;

    task automatic model_step(input int k);
        int              win;
        logic [NREQ-1:0] gbit;
        bit              idle;
        win  = -1;
        gbit = '0;
        idle = (m_hi[k] == 0) && (m_lo[k] == 0);
        if (m_pend[k] != 0 && (idle || (m_hi[k] == 1 && gapv[k] == 0))) begin
            for (int s = 1; s <= NREQ; s++) begin
                if (win < 0 && m_pend[k][(m_rr[k] + s) % NREQ])
                    win = (m_rr[k] + s) % NREQ;
            end
            gbit[win] = 1'b1;
        end
        m_mrg[k]  = req & m_pend[k] & ~gbit;
        m_pend[k] = (m_pend[k] & ~gbit) | req;
        if (win >= 0) begin
            m_hi[k] = (len == 0) ? 1 : int'(len);
            m_lo[k] = 0;
            m_id[k] = win;
            m_rr[k] = win;
        end else if (m_hi[k] > 1) begin
            m_hi[k] = m_hi[k] - 1;
        end else if (m_hi[k] == 1) begin
            m_hi[k] = 0;
            m_lo[k] = gapv[k];
        end else if (m_lo[k] > 0) begin
            m_lo[k] = m_lo[k] - 1;
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_hi[k]   = 0;
                m_lo[k]   = 0;
                m_id[k]   = 0;
                m_rr[k]   = NREQ - 1;
                m_pend[k] = '0;
                m_mrg[k]  = '0;
            end
            m_valid = 1'b1;
        end else if (m_valid) begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        logic [11:0] exp_v;
        if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                exp_v = {(m_hi[k] > 0), 2'(m_id[k]), (m_hi[k] > 0 || m_lo[k] > 0),
                         m_pend[k], m_mrg[k]};
                if (k == 0)
                    check("model_A", {20'd0, oa, ida, busya, penda, mrga}, {20'd0, exp_v});
                else
                    check("model_B", {20'd0, ob, idb, busyb, pendb, mrgb}, {20'd0, exp_v});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] ep;

        // Reset state
        do_reset();
        check("reset_A", {oa, ida, busya, penda, mrga}, 12'h000);
        check("reset_B", {ob, idb, busyb, pendb, mrgb}, 12'h000);

        // Single event, len=3
        len = 4'd3;
        req = 4'b0001;
        tick();
        req = '0;
        check("single_pend", {oa, penda}, {1'b0, 4'b0001});
        tick();
        check("single_hi1", {oa, ida, busya}, {1'b1, 2'd0, 1'b1});
        tick();
        check("single_hi2", oa, 1'b1);
        tick();
        check("single_hi3", oa, 1'b1);
        tick();
        check("single_gap", {oa, busya}, 2'b01);
        tick();
        check("single_idle", {oa, busya}, 2'b00);

        // Round-robin drain, len=2
        do_reset();
        len = 4'd2;
        req = 4'b1111;
        tick();
        req = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            ep = 4'b1110 << k;
            check("rr_order", {oa, ida, penda}, {1'b1, 2'(k), ep});
            repeat (4) tick();
        end

        // Fairness: after id 2, pend=0101 -> 0 then 2
        do_reset();
        len = 4'd2;
        req = 4'b0100;
        tick();
        req = '0;
        tick();
        check("fair_first", {oa, ida}, {1'b1, 2'd2});
        req = 4'b0101;
        tick();
        req = '0;
        check("fair_pend", penda, 4'b0101);
        repeat (3) tick();
        check("fair_second", {oa, ida}, {1'b1, 2'd0});
        repeat (4) tick();
        check("fair_third", {oa, ida}, {1'b1, 2'd2});

        // Merge while busy, len=4
        do_reset();
        len = 4'd4;
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        check("merge_busy", {oa, ida}, {1'b1, 2'd0});
        req = 4'b0010;
        tick();
        check("merge_pend", penda, 4'b0010);
        tick();
        req = '0;
        check("merge_flag", {mrga, penda}, {4'b0010, 4'b0010});
        tick();
        check("merge_clear", mrga, 4'b0000);
        repeat (3) tick();
        check("merge_pulse1", {oa, ida, penda}, {1'b1, 2'd1, 4'b0000});
        repeat (5) tick();
        check("merge_done", {oa, busya, penda}, {1'b0, 1'b0, 4'b0000});

        // Re-arm in grant cycle, back-to-back on GAP=0 instance, len=1
        do_reset();
        len = 4'd1;
        req = 4'b0001;
        tick();
        tick();
        req = '0;
        check("b2b_first", {ob, idb, pendb}, {1'b1, 2'd0, 4'b0001});
        tick();
        check("b2b_second", {ob, idb}, {1'b1, 2'd0});
        check("b2b_gapA", oa, 1'b0);
        tick();
        check("b2b_end", {ob, busyb}, 2'b00);

        // len=0 acts as 1
        do_reset();
        len = 4'd0;
        req = 4'b1000;
        tick();
        req = '0;
        tick();
        check("len0_hi", {oa, ida}, {1'b1, 2'd3});
        tick();
        check("len0_lo", {oa, busya}, 2'b01);

        // Reset mid-pulse, then first grant goes to source 0
        do_reset();
        len = 4'd5;
        req = 4'b0010;
        tick();
        req = '0;
        tick();
        check("rst_pulse", {oa, ida}, {1'b1, 2'd1});
        tick();
        reset = 1'b1;
        req   = 4'b0100;
        tick();
        check("rst_drop_A", {oa, busya, penda, mrga}, 10'd0);
        check("rst_drop_B", {ob, busyb, pendb, mrgb}, 10'd0);
        reset = 1'b0;
        req   = 4'b1111;
        tick();
        req = '0;
        tick();
        check("rst_first_A", {oa, ida}, {1'b1, 2'd0});
        check("rst_first_B", {ob, idb}, {1'b1, 2'd0});

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
